// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: the writeback packet and the default port count.
// Latency: none, type and constant definitions only.
// Backpressure: not applicable.
package cdb_arbiter_pkg;

    localparam int PIPE_WIDTH = 2;

    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [6:0]  preg;
        logic [31:0] data;
    } writeback_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of source-side handshake and CDB broadcast signals between FUs and the arbiter.
// Latency: none, wiring only.
// Backpressure: src_gnt is the only acceptance signal; cdb_* has no ready.
interface cdb_arbiter_if #(
    parameter int NUM_SRC   = 4,
    parameter int NUM_PORTS = cdb_arbiter_pkg::PIPE_WIDTH
);
    logic [NUM_SRC-1:0]                                   src_valid;
    cdb_arbiter_pkg::writeback_packet_t [NUM_SRC-1:0]     src_pkt;
    logic [NUM_SRC-1:0]                                   src_gnt;
    logic [NUM_PORTS-1:0]                                 cdb_valid;
    cdb_arbiter_pkg::writeback_packet_t [NUM_PORTS-1:0]   cdb_pkt;

    // Functional-unit side: presents results, observes grants and broadcasts.
    modport master (
        output src_valid,
        output src_pkt,
        input  src_gnt,
        input  cdb_valid,
        input  cdb_pkt
    );

    // Arbiter side: accepts results and drives the broadcast ports.
    modport slave (
        input  src_valid,
        input  src_pkt,
        output src_gnt,
        output cdb_valid,
        output cdb_pkt
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to NUM_PORTS of NUM_SRC writeback sources onto broadcast ports.
// Latency: grant is combinational in cycle N, broadcast is registered and visible in N+1.
// Backpressure: a source holds valid/pkt until src_gnt; losers age toward forced priority.
module cdb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int NUM_PORTS  = cdb_arbiter_pkg::PIPE_WIDTH,
    parameter int RR_EN      = 1,
    parameter int STARVE_MAX = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = (STARVE_MAX >= 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    if (NUM_PORTS < 1 || NUM_PORTS > NUM_SRC) begin : g_bad_ports
        $error("cdb_arbiter: NUM_PORTS must lie in 1..NUM_SRC");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("cdb_arbiter: STARVE_MAX must be at least 1");
    end

    logic [NUM_PORTS-1:0]                                 r_cdb_vld;
    cdb_arbiter_pkg::writeback_packet_t [NUM_PORTS-1:0]   r_cdb_pkt;
    logic [PTR_W-1:0]                                     r_rr_ptr;
    logic [NUM_SRC-1:0][CNT_W-1:0]                        r_starve;

    logic [NUM_SRC-1:0]                                   w_gnt;
    logic [NUM_PORTS-1:0]                                 w_port_vld;
    logic [NUM_PORTS-1:0][PTR_W-1:0]                      w_port_src;
    logic [PTR_W-1:0]                                     w_rr_base;
    logic [PTR_W-1:0]                                     w_last;
    logic [PTR_W-1:0]                                     w_rr_next;

    // Fixed-priority mode scans from source 0 every cycle.
    assign w_rr_base = (RR_EN != 0) ? r_rr_ptr : '0;

    // Selection: starved sources ascending first, then circular scan from the pointer; fill ports 0 upward.
    always_comb begin
        int               n_sel;
        logic [PTR_W-1:0] idx;
        w_gnt      = '0;
        w_port_vld = '0;
        w_port_src = '0;
        n_sel      = 0;
        idx        = '0;
        if (rst_n && !flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_valid[i] && (r_starve[i] == CNT_MAX) && (n_sel < NUM_PORTS)) begin
                    w_gnt[i] = 1'b1;
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (n_sel == k) begin
                            w_port_vld[k] = 1'b1;
                            w_port_src[k] = PTR_W'(i);
                        end
                    end
                    n_sel++;
                end
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                idx = PTR_W'((int'(w_rr_base) + j) % NUM_SRC);
                if (bus.src_valid[idx] && !w_gnt[idx] && (n_sel < NUM_PORTS)) begin
                    w_gnt[idx] = 1'b1;
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (n_sel == k) begin
                            w_port_vld[k] = 1'b1;
                            w_port_src[k] = idx;
                        end
                    end
                    n_sel++;
                end
            end
        end
    end

    // Next pointer: one past the granted source farthest along the circular order from the base.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = '0;
        w_last = w_rr_base;
        for (int j = 0; j < NUM_SRC; j++) begin
            idx = PTR_W'((int'(w_rr_base) + j) % NUM_SRC);
            if (w_gnt[idx]) begin
                w_last = idx;
            end
        end
        w_rr_next = (w_last == PTR_W'(NUM_SRC - 1)) ? '0 : (w_last + PTR_W'(1));
    end

    // Register broadcasts, advance the pointer on any grant, and age or clear starvation counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cdb_vld <= '0;
            r_cdb_pkt <= '0;
            r_rr_ptr  <= '0;
            r_starve  <= '0;
        end else begin
            r_cdb_vld <= w_port_vld;
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_cdb_pkt[k] <= w_port_vld[k] ? bus.src_pkt[w_port_src[k]] : '0;
            end
            if ((RR_EN != 0) && (|w_gnt)) begin
                r_rr_ptr <= w_rr_next;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (flush || !bus.src_valid[i] || w_gnt[i]) begin
                    r_starve[i] <= '0;
                end else if (r_starve[i] != CNT_MAX) begin
                    r_starve[i] <= r_starve[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.src_gnt   = w_gnt;
    assign bus.cdb_valid = r_cdb_vld;
    assign bus.cdb_pkt   = r_cdb_pkt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Latency: expects grants same cycle and broadcasts one cycle later.
// Backpressure: stimulus holds each valid packet until the model says it was granted.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_a;
    logic flush_b;
    int   n_err = 0;
    int   n_chk = 0;

    cdb_arbiter_if #(.NUM_SRC(4), .NUM_PORTS(2)) bus_a ();
    cdb_arbiter_if #(.NUM_SRC(4), .NUM_PORTS(2)) bus_b ();

    cdb_arbiter #(.NUM_SRC(4), .NUM_PORTS(2), .RR_EN(1), .STARVE_MAX(7)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a)
    );
    cdb_arbiter #(.NUM_SRC(4), .NUM_PORTS(2), .RR_EN(0), .STARVE_MAX(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Reference model state: index 0 = round-robin/STARVE_MAX 7, index 1 = fixed/STARVE_MAX 3.
    int m_rr [2];
    int m_starve [2][4];

    function automatic int smax_of(input int d);
        return (d == 0) ? 7 : 3;
    endfunction

    function automatic void model_reset(input int d);
        m_rr[d] = 0;
        for (int i = 0; i < 4; i++) m_starve[d][i] = 0;
    endfunction

    function automatic void model_arb(input int d, input logic [3:0] v, input logic fl, input logic rs,
                                      output logic [3:0] g, output logic [1:0] pv,
                                      output logic [1:0][1:0] ps);
        int order[$];
        g  = '0;
        pv = '0;
        ps = '0;
        if (!rs || fl) return;
        for (int i = 0; i < 4; i++)
            if (v[i] && m_starve[d][i] == smax_of(d)) order.push_back(i);
        for (int j = 0; j < 4; j++) begin
            int s;
            s = (m_rr[d] + j) % 4;
            if (v[s] && m_starve[d][s] != smax_of(d)) order.push_back(s);
        end
        for (int k = 0; k < 2; k++) begin
            if (k < order.size()) begin
                g[order[k]] = 1'b1;
                pv[k] = 1'b1;
                ps[k] = 2'(order[k]);
            end
        end
    endfunction

    function automatic void model_commit(input int d, input logic [3:0] v, input logic fl,
                                         input logic rs, input logic [3:0] g);
        int far;
        if (!rs) begin
            model_reset(d);
            return;
        end
        if (g != 4'b0) begin
            far = 0;
            for (int i = 0; i < 4; i++)
                if (g[i] && ((i - m_rr[d] + 4) % 4) > far) far = (i - m_rr[d] + 4) % 4;
            m_rr[d] = (d == 0) ? (m_rr[d] + far + 1) % 4 : 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (fl || !v[i] || g[i]) m_starve[d][i] = 0;
            else if (m_starve[d][i] < smax_of(d)) m_starve[d][i] = m_starve[d][i] + 1;
        end
    endfunction

    function automatic writeback_packet_t rnd_pkt();
        writeback_packet_t p;
        p.rob_idx = 6'($urandom);
        p.preg    = 7'($urandom);
        p.data    = $urandom;
        return p;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        bus_a.src_valid = '0;
        bus_b.src_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.src_valid = 4'hF;
        bus_b.src_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus_a.src_pkt[i] = rnd_pkt();
            bus_b.src_pkt[i] = rnd_pkt();
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            n_chk++;
            if (bus_a.src_gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt_a c%0d: got %b want 0000", c, bus_a.src_gnt); end
            n_chk++;
            if (bus_b.src_gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt_b c%0d: got %b want 0000", c, bus_b.src_gnt); end
            @(posedge clk); #1;
            n_chk++;
            if (bus_a.cdb_valid !== 2'b00) begin n_err++; $display("FAIL reset_cdb_valid c%0d: got %b want 00", c, bus_a.cdb_valid); end
            n_chk++;
            if (bus_a.cdb_pkt !== '0) begin n_err++; $display("FAIL reset_cdb_pkt c%0d: got %h want 0", c, bus_a.cdb_pkt); end
        end
        bus_a.src_valid = '0;
        bus_b.src_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (dut_a.r_rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_rr_ptr: got %0d want 0", dut_a.r_rr_ptr); end
    endtask

    task automatic test_round_robin();
        writeback_packet_t p [4];
        logic [3:0] exp_g [3];
        int exp_p0 [3];
        exp_g  = '{4'b0011, 4'b1100, 4'b0011};
        exp_p0 = '{0, 2, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin p[i] = rnd_pkt(); bus_a.src_pkt[i] = p[i]; end
        bus_a.src_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (bus_a.src_gnt !== exp_g[c]) begin n_err++; $display("FAIL rr_gnt c%0d: got %b want %b", c, bus_a.src_gnt, exp_g[c]); end
            @(posedge clk); #1;
            n_chk++;
            if (bus_a.cdb_valid !== 2'b11) begin n_err++; $display("FAIL rr_valid c%0d: got %b want 11", c, bus_a.cdb_valid); end
            n_chk++;
            if (bus_a.cdb_pkt[0] !== p[exp_p0[c]]) begin n_err++; $display("FAIL rr_port0 c%0d: got %h want %h", c, bus_a.cdb_pkt[0], p[exp_p0[c]]); end
            n_chk++;
            if (bus_a.cdb_pkt[1] !== p[exp_p0[c] + 1]) begin n_err++; $display("FAIL rr_port1 c%0d: got %h want %h", c, bus_a.cdb_pkt[1], p[exp_p0[c] + 1]); end
        end
        bus_a.src_valid = '0;
    endtask

    task automatic test_single();
        writeback_packet_t a;
        do_reset();
        a = rnd_pkt();
        for (int i = 0; i < 4; i++) bus_a.src_pkt[i] = rnd_pkt();
        bus_a.src_pkt[2] = a;
        bus_a.src_valid = 4'b0100;
        #1;
        n_chk++;
        if (bus_a.src_gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt: got %b want 0100", bus_a.src_gnt); end
        @(posedge clk); #1;
        bus_a.src_valid = '0;
        n_chk++;
        if (bus_a.cdb_valid !== 2'b01) begin n_err++; $display("FAIL single_valid: got %b want 01", bus_a.cdb_valid); end
        n_chk++;
        if (bus_a.cdb_pkt[0] !== a) begin n_err++; $display("FAIL single_port0: got %h want %h", bus_a.cdb_pkt[0], a); end
        n_chk++;
        if (bus_a.cdb_pkt[1] !== '0) begin n_err++; $display("FAIL single_port1_zero: got %h want 0", bus_a.cdb_pkt[1]); end
        @(posedge clk); #1;
        n_chk++;
        if (bus_a.cdb_valid !== 2'b00 || bus_a.cdb_pkt !== '0) begin
            n_err++; $display("FAIL single_one_cycle: got valid %b pkt %h want 00 / 0", bus_a.cdb_valid, bus_a.cdb_pkt);
        end
    endtask

    task automatic test_starvation();
        writeback_packet_t p [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin p[i] = rnd_pkt(); bus_b.src_pkt[i] = p[i]; end
        bus_b.src_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++;
            if (bus_b.src_gnt !== 4'b0011) begin n_err++; $display("FAIL starve_gnt c%0d: got %b want 0011", c, bus_b.src_gnt); end
            @(posedge clk); #1;
            n_chk++;
            if (bus_b.cdb_pkt[0] !== p[0] || bus_b.cdb_pkt[1] !== p[1]) begin
                n_err++; $display("FAIL starve_pkts c%0d: got %h want %h_%h", c, bus_b.cdb_pkt, p[1], p[0]);
            end
        end
        n_chk++;
        if (dut_b.r_starve[2] !== 2'd3) begin n_err++; $display("FAIL starve_cnt_sat: got %0d want 3", dut_b.r_starve[2]); end
        #1;
        n_chk++;
        if (bus_b.src_gnt !== 4'b0101) begin n_err++; $display("FAIL starve_force_gnt: got %b want 0101", bus_b.src_gnt); end
        @(posedge clk); #1;
        n_chk++;
        if (bus_b.cdb_pkt[0] !== p[2]) begin n_err++; $display("FAIL starve_port0: got %h want %h", bus_b.cdb_pkt[0], p[2]); end
        n_chk++;
        if (bus_b.cdb_pkt[1] !== p[0]) begin n_err++; $display("FAIL starve_port1: got %h want %h", bus_b.cdb_pkt[1], p[0]); end
        n_chk++;
        if (dut_b.r_starve[2] !== 2'd0) begin n_err++; $display("FAIL starve_cnt_clear: got %0d want 0", dut_b.r_starve[2]); end
        #1;
        n_chk++;
        if (bus_b.src_gnt !== 4'b0011) begin n_err++; $display("FAIL starve_after_gnt: got %b want 0011", bus_b.src_gnt); end
        bus_b.src_valid = '0;
    endtask

    task automatic test_flush();
        writeback_packet_t p [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin p[i] = rnd_pkt(); bus_a.src_pkt[i] = p[i]; end
        bus_a.src_valid = 4'hF;
        @(posedge clk); #1;
        flush_a = 1'b1;
        #1;
        n_chk++;
        if (bus_a.src_gnt !== 4'b0) begin n_err++; $display("FAIL flush_gnt: got %b want 0000", bus_a.src_gnt); end
        n_chk++;
        if (bus_a.cdb_valid !== 2'b11 || bus_a.cdb_pkt[0] !== p[0]) begin
            n_err++; $display("FAIL flush_prior_bcast: got valid %b pkt0 %h want 11 / %h", bus_a.cdb_valid, bus_a.cdb_pkt[0], p[0]);
        end
        @(posedge clk); #1;
        flush_a = 1'b0;
        n_chk++;
        if (bus_a.cdb_valid !== 2'b00 || bus_a.cdb_pkt !== '0) begin
            n_err++; $display("FAIL flush_kill: got valid %b pkt %h want 00 / 0", bus_a.cdb_valid, bus_a.cdb_pkt);
        end
        n_chk++;
        if (dut_a.r_rr_ptr !== 2'd2) begin n_err++; $display("FAIL flush_rr_hold: got %0d want 2", dut_a.r_rr_ptr); end
        #1;
        n_chk++;
        if (bus_a.src_gnt !== 4'b1100) begin n_err++; $display("FAIL flush_resume_gnt: got %b want 1100", bus_a.src_gnt); end
        @(posedge clk); #1;
        n_chk++;
        if (bus_a.cdb_valid !== 2'b11 || bus_a.cdb_pkt[0] !== p[2]) begin
            n_err++; $display("FAIL flush_resume_bcast: got valid %b pkt0 %h want 11 / %h", bus_a.cdb_valid, bus_a.cdb_pkt[0], p[2]);
        end
        bus_a.src_valid = '0;
    endtask

    task automatic test_wrap_midreset();
        writeback_packet_t p [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin p[i] = rnd_pkt(); bus_a.src_pkt[i] = p[i]; end
        bus_a.src_valid = 4'b0100;
        @(posedge clk); #1;
        n_chk++;
        if (dut_a.r_rr_ptr !== 2'd3) begin n_err++; $display("FAIL wrap_setup_rr: got %0d want 3", dut_a.r_rr_ptr); end
        bus_a.src_valid = 4'b1001;
        #1;
        n_chk++;
        if (bus_a.src_gnt !== 4'b1001) begin n_err++; $display("FAIL wrap_gnt: got %b want 1001", bus_a.src_gnt); end
        @(posedge clk); #1;
        n_chk++;
        if (dut_a.r_rr_ptr !== 2'd1) begin n_err++; $display("FAIL wrap_rr: got %0d want 1", dut_a.r_rr_ptr); end
        n_chk++;
        if (bus_a.cdb_pkt[0] !== p[3] || bus_a.cdb_pkt[1] !== p[0]) begin
            n_err++; $display("FAIL wrap_ports: got %h want %h_%h", bus_a.cdb_pkt, p[0], p[3]);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus_a.src_gnt !== 4'b0) begin n_err++; $display("FAIL midreset_gnt: got %b want 0000", bus_a.src_gnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_chk++;
        if (bus_a.cdb_valid !== 2'b00 || bus_a.cdb_pkt !== '0) begin
            n_err++; $display("FAIL midreset_cdb: got valid %b pkt %h want 00 / 0", bus_a.cdb_valid, bus_a.cdb_pkt);
        end
        n_chk++;
        if (dut_a.r_rr_ptr !== 2'd0) begin n_err++; $display("FAIL midreset_rr: got %0d want 0", dut_a.r_rr_ptr); end
        #1;
        n_chk++;
        if (bus_a.src_gnt !== 4'b1001) begin n_err++; $display("FAIL postreset_gnt: got %b want 1001", bus_a.src_gnt); end
        @(posedge clk); #1;
        n_chk++;
        if (bus_a.cdb_pkt[0] !== p[0] || bus_a.cdb_pkt[1] !== p[3]) begin
            n_err++; $display("FAIL postreset_ports: got %h want %h_%h", bus_a.cdb_pkt, p[3], p[0]);
        end
        bus_a.src_valid = '0;
    endtask

    task automatic test_random(input int d, input int cycles);
        logic [3:0]        v, g, eg, got_g;
        logic [1:0]        pv, got_v;
        logic [1:0][1:0]   ps;
        logic              fl, rs;
        writeback_packet_t pk [4];
        writeback_packet_t epk [2];
        writeback_packet_t got_p [2];
        do_reset();
        model_reset(d);
        v = '0;
        g = '0;
        for (int i = 0; i < 4; i++) pk[i] = rnd_pkt();
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (g[i] || !v[i]) begin
                    v[i]  = ($urandom_range(0, 99) < 65);
                    pk[i] = rnd_pkt();
                end
            end
            fl = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 49) != 0);
            rst_n = rs;
            if (d == 0) begin
                bus_a.src_valid = v;
                flush_a = fl;
                for (int i = 0; i < 4; i++) bus_a.src_pkt[i] = pk[i];
            end else begin
                bus_b.src_valid = v;
                flush_b = fl;
                for (int i = 0; i < 4; i++) bus_b.src_pkt[i] = pk[i];
            end
            #1;
            model_arb(d, v, fl, rs, eg, pv, ps);
            got_g = (d == 0) ? bus_a.src_gnt : bus_b.src_gnt;
            n_chk++;
            if (got_g !== eg) begin
                n_err++; $display("FAIL rand%0d_gnt c%0d: got %b want %b (valid %b flush %b rst_n %b)", d, c, got_g, eg, v, fl, rs);
            end
            for (int k = 0; k < 2; k++) epk[k] = pv[k] ? pk[ps[k]] : '0;
            model_commit(d, v, fl, rs, eg);
            g = eg;
            @(posedge clk); #1;
            got_v = (d == 0) ? bus_a.cdb_valid : bus_b.cdb_valid;
            for (int k = 0; k < 2; k++) got_p[k] = (d == 0) ? bus_a.cdb_pkt[k] : bus_b.cdb_pkt[k];
            n_chk++;
            if (got_v !== pv) begin n_err++; $display("FAIL rand%0d_valid c%0d: got %b want %b", d, c, got_v, pv); end
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (got_p[k] !== epk[k]) begin
                    n_err++; $display("FAIL rand%0d_port%0d c%0d: got %h want %h", d, k, c, got_p[k], epk[k]);
                end
            end
        end
        rst_n = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        bus_a.src_valid = '0;
        bus_b.src_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        bus_a.src_valid = '0;
        bus_b.src_valid = '0;
        bus_a.src_pkt = '0;
        bus_b.src_pkt = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_starvation();
        test_flush();
        test_wrap_midreset();
        test_random(0, 400);
        test_random(1, 400);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule
